sprite_line_matcher: RTL and testbench

Parametrised per-line sprite matcher. Once per scanline it scans the sprite attribute table for the target line `sy_target`, and emits each Y-matching sprite as a write into a double-buffered active list. While that scan runs, downstream fetch logic reads the count and overflow result of the previous scan. Relative to the earlier matcher it adds a configurable table depth, per-line cap, coordinate width and tile height, plus overflow detection, early termination and an explicit bank select.

---
 rtl/sprite_line_matcher.sv | 150 +++++++++++++++
 tb/tb_sprite_line_matcher.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_matcher.sv
// rtl/sprite_line_matcher.sv - per-scanline sprite Y matcher feeding a double-buffered active list
module sprite_line_matcher #(
  parameter int NUM_SPRITES  = 512,
  parameter int MAX_PER_LINE = 64,
  parameter int Y_WIDTH      = 11,
  parameter int HEIGHT_WIDTH = 4,
  parameter int TILE_SHIFT   = 4,
  localparam int IW = $clog2(NUM_SPRITES),
  localparam int SW = $clog2(MAX_PER_LINE)
) (
  input  logic                        clk_draw,
  input  logic                        rst_draw,
  input  logic                        enable,
  input  logic                        line,
  input  logic [Y_WIDTH-1:0]          sy_target,
  output logic [IW-1:0]               attr_index,
  input  logic [Y_WIDTH-1:0]          attr_y,
  input  logic [HEIGHT_WIDTH-1:0]     attr_height,
  input  logic                        attr_y_flip,
  output logic                        match_we,
  output logic                        match_bank,
  output logic [SW-1:0]               match_slot,
  output logic [IW-1:0]               match_sprite,
  output logic [Y_WIDTH+HEIGHT_WIDTH-1:0] match_row,
  output logic                        rd_bank,
  output logic [SW:0]                 rd_count,
  output logic                        rd_overflow,
  output logic                        scan_busy
);

  // Extra headroom bit keeps attr_y + span from wrapping at the bottom edge.
  localparam int AW = Y_WIDTH + HEIGHT_WIDTH + TILE_SHIFT + 1;
  localparam int RW = Y_WIDTH + HEIGHT_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPRITES - 1);
  localparam logic [SW:0]   MAX_CNT  = (SW+1)'(MAX_PER_LINE);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state;
  state_t          next_state;
  logic            wr_bank;
  logic            issuing;
  logic            data_valid;
  logic [IW-1:0]   eval_index;
  logic [SW:0]     cur_count;
  logic            cur_ovf;

  logic [AW-1:0]   span;
  logic [AW-1:0]   y_ext;
  logic [AW-1:0]   t_ext;
  logic [AW-1:0]   row_full;
  logic [AW-1:0]   sel_row;
  logic            hit;
  logic            has_room;
  logic            eval_last;
  logic            unused_row_msb;

  assign match_bank = wr_bank;
  assign rd_bank    = ~wr_bank;
  assign scan_busy  = (state == SCAN);

  // Y-range test and flip-corrected row for the sprite whose data is on the bus.
  always_comb begin
    span      = AW'(attr_height) << TILE_SHIFT;
    y_ext     = AW'(attr_y);
    t_ext     = AW'(sy_target);
    row_full  = t_ext - y_ext;
    sel_row   = attr_y_flip ? (span - AW'(1) - row_full) : row_full;
    hit       = enable && data_valid && (state == SCAN) && (attr_height != '0) &&
                (t_ext >= y_ext) && (t_ext < (y_ext + span));
    has_room  = (cur_count < MAX_CNT);
    eval_last = data_valid && (eval_index == LAST_IDX);
  end

  // Rows never exceed the tallest sprite, so the top bits are always zero.
  assign unused_row_msb = ^sel_row[AW-1:RW];

  // State register.
  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) state <= IDLE;
    else          state <= next_state;
  end

  // Next state: line restarts from anywhere; a scan ends on its last entry or on overflow.
  always_comb begin
    next_state = state;
    if (line) begin
      next_state = SCAN;
    end else begin
      case (state)
        SCAN:    if ((hit && !has_room) || eval_last) next_state = DONE;
        default: next_state = state;
      endcase
    end
  end

  // Address issue, match write-out, and publication of the finished line's result.
  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      wr_bank      <= 1'b0;
      issuing      <= 1'b0;
      data_valid   <= 1'b0;
      eval_index   <= '0;
      attr_index   <= '0;
      cur_count    <= '0;
      cur_ovf      <= 1'b0;
      rd_count     <= '0;
      rd_overflow  <= 1'b0;
      match_we     <= 1'b0;
      match_slot   <= '0;
      match_sprite <= '0;
      match_row    <= '0;
    end else if (line) begin
      wr_bank     <= ~wr_bank;
      rd_count    <= cur_count;
      rd_overflow <= cur_ovf;
      cur_count   <= '0;
      cur_ovf     <= 1'b0;
      attr_index  <= '0;
      issuing     <= 1'b1;
      data_valid  <= 1'b0;
      match_we    <= 1'b0;
    end else begin
      match_we <= 1'b0;
      if ((state == SCAN) && (next_state == SCAN)) begin
        data_valid <= issuing;
        eval_index <= attr_index;
        if (issuing) begin
          if (attr_index == LAST_IDX) issuing <= 1'b0;
          else                        attr_index <= attr_index + 1'b1;
        end
      end else begin
        issuing    <= 1'b0;
        data_valid <= 1'b0;
      end
      if (hit) begin
        if (has_room) begin
          match_we     <= 1'b1;
          match_slot   <= cur_count[SW-1:0];
          match_sprite <= eval_index;
          match_row    <= sel_row[RW-1:0];
          cur_count    <= cur_count + 1'b1;
        end else begin
          cur_ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_matcher.sv
// tb/tb_sprite_line_matcher.sv - scoreboard bench for sprite_line_matcher
module tb_sprite_line_matcher;

  localparam int NS  = 32;
  localparam int MPL = 8;
  localparam int YW  = 11;
  localparam int HW  = 4;
  localparam int TS  = 4;
  localparam int IW  = $clog2(NS);
  localparam int SW  = $clog2(MPL);

  logic               clk_draw;
  logic               rst_draw;
  logic               enable;
  logic               line;
  logic [YW-1:0]      sy_target;
  logic [IW-1:0]      attr_index;
  logic [YW-1:0]      attr_y;
  logic [HW-1:0]      attr_height;
  logic               attr_y_flip;
  logic               match_we;
  logic               match_bank;
  logic [SW-1:0]      match_slot;
  logic [IW-1:0]      match_sprite;
  logic [YW+HW-1:0]   match_row;
  logic               rd_bank;
  logic [SW:0]        rd_count;
  logic               rd_overflow;
  logic               scan_busy;

  typedef struct {
    int slot;
    int sprite;
    int row;
  } wr_t;

  wr_t exp_q[$];
  int  tbl_y    [NS];
  int  tbl_h    [NS];
  int  tbl_flip [NS];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  pub_count = 0;
  bit  pub_ovf   = 0;
  bit  exp_bank  = 0;

  sprite_line_matcher #(
    .NUM_SPRITES(NS), .MAX_PER_LINE(MPL), .Y_WIDTH(YW),
    .HEIGHT_WIDTH(HW), .TILE_SHIFT(TS)
  ) dut (
    .clk_draw(clk_draw), .rst_draw(rst_draw), .enable(enable), .line(line),
    .sy_target(sy_target), .attr_index(attr_index), .attr_y(attr_y),
    .attr_height(attr_height), .attr_y_flip(attr_y_flip), .match_we(match_we),
    .match_bank(match_bank), .match_slot(match_slot), .match_sprite(match_sprite),
    .match_row(match_row), .rd_bank(rd_bank), .rd_count(rd_count),
    .rd_overflow(rd_overflow), .scan_busy(scan_busy)
  );

  initial clk_draw = 1'b0;
  always #5 clk_draw = ~clk_draw;

  // Synchronous attribute table: data follows the address by one cycle.
  always @(posedge clk_draw) begin
    attr_y      <= YW'(tbl_y[attr_index]);
    attr_height <= HW'(tbl_h[attr_index]);
    attr_y_flip <= tbl_flip[attr_index][0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pop one expected write per observed strobe.
  always @(negedge clk_draw) begin : mon_blk
    wr_t w;
    if (!rst_draw && match_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", match_we, 0);
      end else begin
        w = exp_q.pop_front();
        check("match_slot",   match_slot,   w.slot);
        check("match_sprite", match_sprite, w.sprite);
        check("match_row",    match_row,    w.row);
        check("match_bank",   match_bank,   exp_bank);
      end
    end
  end

  task automatic clear_table();
    for (int i = 0; i < NS; i++) begin
      tbl_y[i] = 0; tbl_h[i] = 0; tbl_flip[i] = 0;
    end
  endtask

  task automatic set_sprite(input int idx, input int y, input int h, input int flip);
    tbl_y[idx] = y; tbl_h[idx] = h; tbl_flip[idx] = flip;
  endtask

  task automatic build_model(input int target, input bit en);
    int cnt;
    bit ovf;
    cnt = 0;
    ovf = 0;
    exp_q.delete();
    if (en) begin
      for (int i = 0; i < NS; i++) begin
        int y;
        int h;
        wr_t w;
        y = tbl_y[i];
        h = tbl_h[i];
        if (h != 0 && target >= y && target < y + (h << TS)) begin
          if (cnt < MPL) begin
            w.slot   = cnt;
            w.sprite = i;
            w.row    = (tbl_flip[i] != 0) ? (h << TS) - 1 - (target - y) : target - y;
            exp_q.push_back(w);
            cnt++;
          end else begin
            ovf = 1;
            break;
          end
        end
      end
    end
    pub_count = cnt;
    pub_ovf   = ovf;
  endtask

  task automatic pulse_line(input int target, input bit en);
    check("writes_drained", exp_q.size(), 0);
    @(negedge clk_draw);
    sy_target = YW'(target);
    enable    = en;
    line      = 1'b1;
    #1;
    check("we_in_line_cycle", match_we, 0);
    @(posedge clk_draw);
    #1;
    line = 1'b0;
    exp_bank = !exp_bank;
    check("rd_count",    rd_count,    pub_count);
    check("rd_overflow", rd_overflow, pub_ovf);
    check("rd_bank",     rd_bank,     !exp_bank);
    check("scan_start",  scan_busy,   1);
    check("index_start", attr_index,  0);
    build_model(target, en);
  endtask

  task automatic wait_done();
    bit done;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_draw);
      if (!scan_busy) begin
        done = 1;
        break;
      end
    end
    check("scan_done", done, 1);
    @(negedge clk_draw);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int fall_edge;
    rst_draw  = 1'b1;
    line      = 1'b0;
    enable    = 1'b1;
    sy_target = '0;
    clear_table();
    #2;
    check("rst_attr_index", attr_index, 0);
    check("rst_match_we",   match_we,   0);
    check("rst_scan_busy",  scan_busy,  0);
    check("rst_rd_bank",    rd_bank,    1);
    check("rst_rd_count",   rd_count,   0);
    check("rst_match_bank", match_bank, 0);
    repeat (2) @(negedge clk_draw);
    rst_draw = 1'b0;
    repeat (2) @(negedge clk_draw);

    // Eight sprites covering line 110.
    for (int i = 0; i < 8; i++) set_sprite(i, 100, 2, 0);
    pulse_line(110, 1);
    wait_done();

    // Vertical flip, then the line just below the sprite.
    clear_table();
    set_sprite(0, 100, 1, 1);
    pulse_line(100, 1);
    wait_done();
    pulse_line(116, 1);
    wait_done();

    // Capacity overflow with early stop.
    clear_table();
    for (int i = 0; i < MPL + 3; i++) set_sprite(i, 50, 1, 0);
    pulse_line(50, 1);
    fall_edge = 0;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk_draw);
      #1;
      if (!scan_busy) begin
        fall_edge = j;
        break;
      end
    end
    check("busy_fall_edge", fall_edge, MPL + 2);
    wait_done();

    // Bottom-edge straddle, disabled sprite, and one plain hit.
    clear_table();
    set_sprite(0, 2040, 2, 0);
    set_sprite(1, 3, 0, 0);
    set_sprite(2, 0, 1, 0);
    pulse_line(3, 1);
    wait_done();

    // Abort after twenty scan cycles.
    clear_table();
    for (int i = 0; i < 5; i++) set_sprite(i, 200, 1, 0);
    pulse_line(205, 1);
    repeat (20) @(negedge clk_draw);
    check("busy_before_abort", scan_busy, 1);
    pulse_line(205, 1);
    wait_done();

    // Matching disabled, then enabled again on the same table.
    clear_table();
    for (int i = 0; i < 8; i++) set_sprite(i, 100, 2, 0);
    pulse_line(110, 0);
    wait_done();
    pulse_line(110, 1);
    wait_done();

    // Asynchronous reset in the middle of a scan.
    pulse_line(110, 1);
    repeat (4) @(posedge clk_draw);
    #3;
    rst_draw = 1'b1;
    #1;
    check("arst_match_we",     match_we,     0);
    check("arst_match_slot",   match_slot,   0);
    check("arst_match_sprite", match_sprite, 0);
    check("arst_match_row",    match_row,    0);
    check("arst_attr_index",   attr_index,   0);
    check("arst_scan_busy",    scan_busy,    0);
    check("arst_rd_bank",      rd_bank,      1);
    check("arst_rd_count",     rd_count,     0);
    check("arst_rd_overflow",  rd_overflow,  0);
    exp_q.delete();
    exp_bank  = 0;
    pub_count = 0;
    pub_ovf   = 0;
    @(negedge clk_draw);
    rst_draw = 1'b0;
    pulse_line(110, 1);
    wait_done();
    pulse_line(110, 1);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
